video_frame_checker: RTL and testbench
======================================

Name: video_frame_checker

Overview:
- Sink-side checker for the colour-bar video path.
- Taps the RGB stream plus video_on/vsync at the output of the pixel generator (or the panel input) and measures active width and height per frame.
- Compares every active pixel against the expected 16-bar palette and accumulates mismatches.
- Reports a per-frame pass/fail and a lock indication for bring-up and regression benches.

Parameters:
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- BARS, 16, number of vertical bars
- BAR_W, H_ACTIVE/BARS (40), bar width in pixels
- MM_W, 20, mismatch counter width

Ports:
- rfr_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- chk_en  in  1  enable; low forces IDLE
- video_on  in  1  active-video qualifier
- vsync  in  1  vertical sync, active-high
- p_red  in  8  red pixel
- p_green  in  8  green pixel
- p_blue  in  8  blue pixel
- frame_done  out  1  one-cycle pulse when results update
- meas_width  out  12  active pixels of the last line of the last frame
- meas_height  out  12  active lines of the last frame
- mismatch_cnt  out  MM_W  pixel mismatches in the last frame
- width_err  out  1  line widths inconsistent within the last frame
- frame_ok  out  1  last frame passed
- locked  out  1  two consecutive passing frames seen

Behaviour:
- Reset values: all outputs 0; state IDLE; all internal counters 0.
- Inputs are registered once on entry; all latencies below are counted from the registered samples.
- Edge detection uses the registered vsync and video_on against one further delayed copy:
  - vs_rise = vsync rising edge
  - line_end = video_on falling edge
- FSM states:
  - IDLE: stays while chk_en=0. When chk_en=1, go to SYNC.
  - SYNC: wait for vs_rise, then go to ACTIVE with x, y, mismatch and width_err cleared. Data before the first vs_rise is ignored.
  - ACTIVE:
    - Each cycle with video_on=1: compare pixel at x; x <= x+1, saturating at 4095.
    - On line_end: y <= y+1 (saturating at 4095); cur_w <= x; x <= 0. If y>0 and x differs from the previous line width, set width_err.
    - On vs_rise: go to REPORT.
  - REPORT: one cycle. Latch meas_width=cur_w, meas_height=y, mismatch_cnt, and width_err. Pulse frame_done=1. Update frame_ok and locked. Clear the working counters and return to ACTIVE. The vs_rise that ends frame N also starts frame N+1, so no frame is skipped.
- Pixel compare:
  - Expected colour = palette(x / BAR_W) from the package.
  - Any pixel with x >= H_ACTIVE is a mismatch.
  - Each mismatching pixel increments mismatch_cnt, which saturates at all-ones and never wraps.
- Palette, bar index 0..15:
  - 0: FFFFFF
  - 1: FF0000
  - 2: FF8000
  - 3: FFFF00
  - 4: 80FF00
  - 5: 00FF00
  - 6: 00FF80
  - 7: 00FFFF
  - 8: 0080FF
  - 9: 0000FF
  - 10: 8000FF
  - 11: FF00FF
  - 12: FF0080
  - 13: E0E0E0
  - 14: 808080
  - 15: 000000
- frame_ok = (meas_width==H_ACTIVE) && (meas_height==V_ACTIVE) && (mismatch_cnt==0) && !width_err.
- locked:
  - Sets on the second consecutive frame_ok.
  - Clears on any frame with frame_ok=0.
  - Held while running; cleared when chk_en drops.
- Simultaneous events:
  - line_end and vs_rise in the same cycle: the line is counted first, then REPORT.
  - video_on high at vs_rise: that pixel belongs to the new frame.
- chk_en deasserted mid-frame: return to IDLE next cycle and discard partial counts. Latched outputs hold, except locked, which clears.
- reset_n asserted mid-frame: immediate return to reset values.
- Frame with zero active lines: meas_height=0 and frame_ok=0.

Decomposition:
- Package video_chk_pkg holds:
  - the state enum (IDLE, SYNC, ACTIVE, REPORT)
  - the palette constant array, 16 entries of 24 bits
  - the function exp_rgb(bar_idx)
  - the counter width constant (12)
- One sub-module, vid_edge_det: registers the input and produces rise/fall pulses. Instantiated for vsync and for video_on.

Test Plan:
- Ideal 640x480 bar pattern, 3 frames -> frame_done pulses ×2 after the first sync; meas_width=640, meas_height=480, mismatch_cnt=0, frame_ok=1; locked=1 after the 2nd report.
- Corrupt pixel x=45, y=10 to 000000 -> mismatch_cnt=1, frame_ok=0, locked clears.
- Line 100 shortened to 639 pixels -> width_err=1, frame_ok=0; next clean frame gives width_err=0 and frame_ok=1, but locked stays 0 until a second clean frame.
- 650-pixel lines -> meas_width=650, mismatch_cnt=10×480=4800, frame_ok=0.
- Force every pixel wrong with MM_W=8 -> mismatch_cnt saturates at 255 and does not wrap.
- Drop chk_en mid-frame, then re-enable -> FSM goes IDLE then SYNC; no frame_done until the second vs_rise after re-enable; reset_n pulse mid-frame returns all outputs to 0.

Source files
------------

// File: rtl/video_chk_pkg.sv
// Shared types and constants for the colour-bar frame checker.
package video_chk_pkg;

  localparam int CW    = 12;
  localparam int PIX_W = 8;

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, REPORT} state_e;

  // Entry 0 sits in the low 24 bits, entry 15 in the top 24 bits.
  localparam logic [15:0][23:0] PALETTE = {
    24'h000000, 24'h808080, 24'hE0E0E0, 24'hFF0080,
    24'hFF00FF, 24'h8000FF, 24'h0000FF, 24'h0080FF,
    24'h00FFFF, 24'h00FF80, 24'h00FF00, 24'h80FF00,
    24'hFFFF00, 24'hFF8000, 24'hFF0000, 24'hFFFFFF
  };

  function automatic logic [23:0] exp_rgb(input logic [3:0] bar_idx);
    return PALETTE[bar_idx];
  endfunction

endpackage

// File: rtl/video_frame_checker_if.sv
// Video stream tap: qualifier, vertical sync and RGB pixel.
interface video_frame_checker_if;
  import video_chk_pkg::*;

  logic             video_on;
  logic             vsync;
  logic [PIX_W-1:0] p_red;
  logic [PIX_W-1:0] p_green;
  logic [PIX_W-1:0] p_blue;

  modport master (output video_on, vsync, p_red, p_green, p_blue);
  modport slave  (input  video_on, vsync, p_red, p_green, p_blue);
endinterface

// File: rtl/vid_edge_det.sv
// Registers a 1-bit input and flags its rising/falling edges against a delayed copy.
module vid_edge_det (
  input  logic rfr_clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q;

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
    end
  end

  assign lvl_o  = s1_q;
  assign rise_o = s1_q & ~s2_q;
  assign fall_o = ~s1_q & s2_q;

endmodule

// File: rtl/video_frame_checker.sv
// Measures active width/height per frame, counts palette mismatches, reports pass and lock.
module video_frame_checker
  import video_chk_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BARS     = 16,
  parameter int BAR_W    = H_ACTIVE / BARS,
  parameter int MM_W     = 20
) (
  input  logic                 rfr_clk,
  input  logic                 reset_n,
  input  logic                 chk_en,
  video_frame_checker_if.slave vid,
  output logic                 frame_done,
  output logic [CW-1:0]        meas_width,
  output logic [CW-1:0]        meas_height,
  output logic [MM_W-1:0]      mismatch_cnt,
  output logic                 width_err,
  output logic                 frame_ok,
  output logic                 locked
);

  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [MM_W-1:0] mm_inc(input logic [MM_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic pix_bad(input logic [CW-1:0] px, input logic [23:0] rgb);
    if (px >= CW'(H_ACTIVE)) return 1'b1;
    return rgb != exp_rgb(4'(px / CW'(BAR_W)));
  endfunction

  logic        von, line_end, vs_rise;
  logic        unused_vs_lvl, unused_vs_fall, unused_von_rise;
  logic [23:0] rgb_q;

  vid_edge_det u_vs_det (
    .rfr_clk(rfr_clk), .reset_n(reset_n), .sig_i(vid.vsync),
    .lvl_o(unused_vs_lvl), .rise_o(vs_rise), .fall_o(unused_vs_fall)
  );

  vid_edge_det u_von_det (
    .rfr_clk(rfr_clk), .reset_n(reset_n), .sig_i(vid.video_on),
    .lvl_o(von), .rise_o(unused_von_rise), .fall_o(line_end)
  );

  always_ff @(posedge rfr_clk) rgb_q <= {vid.p_red, vid.p_green, vid.p_blue};

  state_e state_q, state_d;
  logic   count_en, restart, snap_en, publish, idle_clr;

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (chk_en)  state_d = SYNC;
      SYNC:    if (vs_rise) state_d = ACTIVE;
      ACTIVE:  if (vs_rise) state_d = REPORT;
      REPORT:  state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
    if (!chk_en) state_d = IDLE;
  end

  always_comb begin
    count_en = 1'b0;
    restart  = 1'b0;
    snap_en  = 1'b0;
    publish  = 1'b0;
    idle_clr = 1'b0;
    unique case (state_q)
      IDLE:    idle_clr = 1'b1;
      SYNC:    restart  = vs_rise;
      ACTIVE:  begin count_en = 1'b1; restart = vs_rise; snap_en = vs_rise; end
      REPORT:  begin count_en = 1'b1; publish = 1'b1; end
      default: ;
    endcase
  end

  logic [CW-1:0]   x_q, x_d, y_q, y_d, curw_q, curw_d, sw_q, sw_d, sh_q, sh_d;
  logic [MM_W-1:0] mm_q, mm_d, smm_q, smm_d;
  logic            werr_q, werr_d, swerr_q, swerr_d, prev_ok_q, ok_now;

  always_comb begin
    x_d = x_q;  y_d = y_q;  curw_d = curw_q;  mm_d = mm_q;  werr_d = werr_q;
    sw_d = sw_q;  sh_d = sh_q;  smm_d = smm_q;  swerr_d = swerr_q;
    if (count_en) begin
      if (von) begin
        x_d = cnt_inc(x_q);
        if (pix_bad(x_q, rgb_q)) mm_d = mm_inc(mm_q);
      end
      if (line_end) begin
        y_d    = cnt_inc(y_q);
        curw_d = x_q;
        x_d    = '0;
        if (y_q != '0 && x_q != curw_q) werr_d = 1'b1;
      end
    end
    if (snap_en) begin
      sw_d = curw_d;  sh_d = y_d;  smm_d = mm_d;  swerr_d = werr_d;
    end
    // The pixel coincident with vs_rise opens the new frame at x = 0.
    if (restart) begin
      x_d    = von ? CW'(1) : '0;
      mm_d   = (von && pix_bad('0, rgb_q)) ? MM_W'(1) : '0;
      y_d    = '0;
      curw_d = '0;
      werr_d = 1'b0;
    end
    if (idle_clr) begin
      x_d = '0;  y_d = '0;  curw_d = '0;  mm_d = '0;  werr_d = 1'b0;
    end
  end

  assign ok_now = (sw_q == CW'(H_ACTIVE)) && (sh_q == CW'(V_ACTIVE)) &&
                  (smm_q == '0) && !swerr_q;

  always_ff @(posedge rfr_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;  y_q <= '0;  curw_q <= '0;  mm_q <= '0;  werr_q <= 1'b0;
      sw_q <= '0;  sh_q <= '0;  smm_q <= '0;  swerr_q <= 1'b0;
      meas_width <= '0;  meas_height <= '0;  mismatch_cnt <= '0;
      width_err <= 1'b0;  frame_ok <= 1'b0;  locked <= 1'b0;
      prev_ok_q <= 1'b0;  frame_done <= 1'b0;
    end else begin
      x_q <= x_d;  y_q <= y_d;  curw_q <= curw_d;  mm_q <= mm_d;  werr_q <= werr_d;
      sw_q <= sw_d;  sh_q <= sh_d;  smm_q <= smm_d;  swerr_q <= swerr_d;
      frame_done <= publish;
      if (publish) begin
        meas_width   <= sw_q;
        meas_height  <= sh_q;
        mismatch_cnt <= smm_q;
        width_err    <= swerr_q;
        frame_ok     <= ok_now;
        locked       <= ok_now & prev_ok_q;
        prev_ok_q    <= ok_now;
      end else if (idle_clr) begin
        locked    <= 1'b0;
        prev_ok_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_frame_checker.sv
// Directed bench for video_frame_checker on a scaled 64x12 bar pattern with a result scoreboard.
module tb_video_frame_checker;

  localparam int H  = 64;
  localparam int V  = 12;
  localparam int BW = 4;
  localparam int HB = 4;

  logic clk = 1'b0;
  logic reset_n, chk_en;
  always #5 clk = ~clk;

  video_frame_checker_if vif ();

  logic        fd, werr, ok, lk;
  logic [11:0] mw, mh;
  logic [19:0] mm;
  logic        fd8, werr8, ok8, lk8;
  logic [11:0] mw8, mh8;
  logic [7:0]  mm8;

  video_frame_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .MM_W(20)) dut (
    .rfr_clk(clk), .reset_n(reset_n), .chk_en(chk_en), .vid(vif),
    .frame_done(fd), .meas_width(mw), .meas_height(mh), .mismatch_cnt(mm),
    .width_err(werr), .frame_ok(ok), .locked(lk)
  );

  video_frame_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .MM_W(8)) dut8 (
    .rfr_clk(clk), .reset_n(reset_n), .chk_en(chk_en), .vid(vif),
    .frame_done(fd8), .meas_width(mw8), .meas_height(mh8), .mismatch_cnt(mm8),
    .width_err(werr8), .frame_ok(ok8), .locked(lk8)
  );

  logic [23:0] pal [16] = '{
    24'hFFFFFF, 24'hFF0000, 24'hFF8000, 24'hFFFF00,
    24'h80FF00, 24'h00FF00, 24'h00FF80, 24'h00FFFF,
    24'h0080FF, 24'h0000FF, 24'h8000FF, 24'hFF00FF,
    24'hFF0080, 24'hE0E0E0, 24'h808080, 24'h000000
  };

  typedef struct {
    int w; int h; int mm; int mm8;
    bit werr; bit ok; bit lk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   armed = 0;
  bit   enabled = 0;
  bit   prev_ok = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame_done"}, 32'(fd), 0);
    chk({tag, "_meas_width"}, 32'(mw), 0);
    chk({tag, "_meas_height"}, 32'(mh), 0);
    chk({tag, "_mismatch_cnt"}, 32'(mm), 0);
    chk({tag, "_width_err"}, 32'(werr), 0);
    chk({tag, "_frame_ok"}, 32'(ok), 0);
    chk({tag, "_locked"}, 32'(lk), 0);
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    vif.vsync = 1'b1;
    vif.video_on = 1'b0;
    repeat (2) @(negedge clk);
    vif.vsync = 1'b0;
    repeat (3) @(negedge clk);
    if (enabled) armed = 1;
  endtask

  task automatic send_frame(input int lines, input int width, input int sl, input int sw,
                            input int bx, input int by, input bit allbad);
    exp_t e;
    int   w, mcount;
    bit   we;
    w = 0; mcount = 0; we = 0;
    for (int y = 0; y < lines; y++) begin
      int lw;
      lw = (y == sl) ? sw : width;
      if (y > 0 && lw != w) we = 1;
      w = lw;
      for (int x = 0; x < lw; x++) begin
        logic [23:0] good, c;
        good = (x < H) ? pal[x / BW] : 24'h000000;
        c = allbad ? ~good : good;
        if (x == bx && y == by) c = 24'h000000;
        if (x >= H || c != good) mcount++;
        @(negedge clk);
        vif.video_on = 1'b1;
        {vif.p_red, vif.p_green, vif.p_blue} = c;
      end
      @(negedge clk);
      vif.video_on = 1'b0;
      repeat (HB - 1) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    if (armed) begin
      e.w = w; e.h = lines; e.mm = mcount;
      e.mm8 = (mcount > 255) ? 255 : mcount;
      e.werr = we;
      e.ok = (w == H) && (lines == V) && (mcount == 0) && !we;
      e.lk = e.ok && prev_ok;
      prev_ok = e.ok;
      sb.push_back(e);
    end
  endtask

  task automatic clean_frame();
    send_frame(V, H, -1, 0, -1, -1, 0);
  endtask

  always @(negedge clk) begin
    if (fd) begin
      chk("report_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("meas_width", 32'(mw), e.w);
        chk("meas_height", 32'(mh), e.h);
        chk("mismatch_cnt", 32'(mm), e.mm);
        chk("mismatch_cnt_w8", 32'(mm8), e.mm8);
        chk("width_err", 32'(werr), 32'(e.werr));
        chk("frame_ok", 32'(ok), 32'(e.ok));
        chk("locked", 32'(lk), 32'(e.lk));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    chk_en  = 1'b0;
    vif.video_on = 1'b0;
    vif.vsync = 1'b0;
    {vif.p_red, vif.p_green, vif.p_blue} = 24'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Ideal frames: first report passes, second report locks.
    chk_en = 1'b1; enabled = 1;
    repeat (3) @(negedge clk);
    vs_pulse();
    clean_frame(); vs_pulse();
    clean_frame(); vs_pulse();

    // Single corrupt pixel drops lock.
    send_frame(V, H, -1, 0, 45, 10, 0); vs_pulse();

    // Short line, then two clean frames to relock.
    send_frame(V, H, 5, H - 1, -1, -1, 0); vs_pulse();
    clean_frame(); vs_pulse();
    clean_frame(); vs_pulse();

    // Over-wide lines and an all-wrong frame (8-bit counter saturates).
    send_frame(V, H + 10, -1, 0, -1, -1, 0); vs_pulse();
    send_frame(V, H, -1, 0, -1, -1, 1); vs_pulse();

    // Frame with no active lines.
    send_frame(0, H, -1, 0, -1, -1, 0); vs_pulse();

    // Relock, then drop chk_en mid-frame.
    clean_frame(); vs_pulse();
    clean_frame(); vs_pulse();
    repeat (10) @(negedge clk);
    chk("locked_before_drop", 32'(lk), 1);
    armed = 0;
    send_frame(4, H, -1, 0, -1, -1, 0);
    chk_en = 1'b0; enabled = 0; prev_ok = 0;
    repeat (3) @(negedge clk);
    chk("locked_after_drop", 32'(lk), 0);
    chk("height_holds_after_drop", 32'(mh), V);
    chk("width_holds_after_drop", 32'(mw), H);
    chk_en = 1'b1; enabled = 1;
    repeat (3) @(negedge clk);
    vs_pulse();
    clean_frame(); vs_pulse();

    // Asynchronous reset in the middle of a frame.
    armed = 0;
    send_frame(3, H, -1, 0, -1, -1, 0);
    @(negedge clk);
    vif.video_on = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_all_zero("midframe_reset");
    @(negedge clk);
    vif.video_on = 1'b0;
    reset_n = 1'b1;
    prev_ok = 0;
    repeat (3) @(negedge clk);
    vs_pulse();
    clean_frame(); vs_pulse();

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
